// File: rtl/itree_pkg.sv
// Shared types and tree geometry for the isolation-tree path scorer.
// The node layout is fixed by the PKG_* values below.
package itree_pkg;

    localparam int unsigned PKG_DATA_W   = 8;
    localparam int unsigned PKG_NUM_FEAT = 2;
    localparam int unsigned PKG_DEPTH    = 3;

    localparam int unsigned N_NODES = (2 ** PKG_DEPTH) - 1;
    localparam int unsigned NODE_AW = $clog2(N_NODES);
    localparam int unsigned DEPTH_W = $clog2(PKG_DEPTH + 1);
    localparam int unsigned FEAT_W  = (PKG_NUM_FEAT > 1) ? $clog2(PKG_NUM_FEAT) : 1;
    // A walk may step one level below the last stored node, so indices need one more bit.
    localparam int unsigned NODE_W  = PKG_DEPTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } state_t;

    typedef struct packed {
        logic                  leaf;
        logic [FEAT_W-1:0]     feat;
        logic [PKG_DATA_W-1:0] thresh;
    } node_t;

    localparam node_t LEAF_NODE = '{leaf: 1'b1, feat: '0, thresh: '0};

endpackage

// File: rtl/itree_node_table.sv
// Split-node register file: async reset to all-leaf, one synchronous write port,
// two combinational read ports (walk lookup and pre-write snapshot).
module itree_node_table
    import itree_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we_i,
    input  logic [NODE_AW-1:0] waddr_i,
    input  node_t              wdata_i,
    input  logic [NODE_AW-1:0] raddr_i,
    output node_t              rdata_o,
    input  logic [NODE_AW-1:0] praddr_i,
    output node_t              prdata_o
);

    node_t mem_q [N_NODES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_NODES; i++) begin
                mem_q[i] <= LEAF_NODE;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o  = mem_q[raddr_i];
    assign prdata_o = mem_q[praddr_i];

endmodule

// File: rtl/itree_path_scorer.sv
// Isolation-tree evaluator: walks one tree level per clock for each accepted
// sample and reports path length, anomaly flag and a saturating anomaly count.
module itree_path_scorer
    import itree_pkg::*;
#(
    parameter int unsigned DATA_W   = PKG_DATA_W,
    parameter int unsigned NUM_FEAT = PKG_NUM_FEAT,
    parameter int unsigned DEPTH    = PKG_DEPTH,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [NODE_AW-1:0]         cfg_addr,
    input  logic [FEAT_W-1:0]          cfg_feat,
    input  logic [DATA_W-1:0]          cfg_thresh,
    input  logic                       cfg_leaf,
    output logic                       cfg_err,
    input  logic [DEPTH_W-1:0]         anom_thr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_FEAT*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DEPTH_W-1:0]         out_depth,
    output logic                       out_anomaly,
    output logic [CNT_W-1:0]           anomaly_count
);

    state_t                     state_q, state_d;
    logic [NUM_FEAT*DATA_W-1:0] sample_q, sample_d;
    logic [DEPTH_W-1:0]         thr_q, thr_d;
    logic [NODE_W-1:0]          node_q, node_d;
    logic [DEPTH_W-1:0]         depth_q, depth_d;
    logic [DEPTH_W-1:0]         out_depth_q, out_depth_d;
    logic                       out_anom_q, out_anom_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       cfg_err_q, cfg_err_d;
    logic                       shd_vld_q, shd_vld_d;
    logic [NODE_AW-1:0]         shd_addr_q, shd_addr_d;
    node_t                      shd_node_q, shd_node_d;

    logic                       addr_ok;
    logic                       tbl_we;
    node_t                      cfg_node;
    node_t                      rd_node;
    node_t                      old_node;
    node_t                      cur_node;
    logic [FEAT_W-1:0]          feat_idx;
    logic [DATA_W-1:0]          feat_val;
    logic                       go_left;
    logic                       at_leaf;

    assign addr_ok  = (32'(cfg_addr) < N_NODES);
    assign tbl_we   = cfg_we && (state_q == IDLE) && addr_ok;
    assign cfg_node = '{leaf: cfg_leaf, feat: cfg_feat, thresh: cfg_thresh};

    itree_node_table u_table (
        .clk_i    (clk),
        .rst_ni   (reset),
        .we_i     (tbl_we),
        .waddr_i  (cfg_addr),
        .wdata_i  (cfg_node),
        .raddr_i  (node_q[NODE_AW-1:0]),
        .rdata_o  (rd_node),
        .praddr_i (cfg_addr),
        .prdata_o (old_node)
    );

    // A write committed with the accepting edge must stay invisible to that sample,
    // so the overwritten entry is kept aside and substituted during the walk.
    always_comb begin
        cur_node = rd_node;
        if (shd_vld_q && (node_q == NODE_W'(shd_addr_q))) begin
            cur_node = shd_node_q;
        end
    end

    always_comb begin
        feat_idx = (32'(cur_node.feat) < NUM_FEAT) ? cur_node.feat : '0;
        feat_val = '0;
        for (int unsigned k = 0; k < NUM_FEAT; k++) begin
            if (32'(feat_idx) == k) begin
                feat_val = sample_q[k*DATA_W +: DATA_W];
            end
        end
        go_left = (feat_val < cur_node.thresh);
        at_leaf = cur_node.leaf || (32'(depth_q) == DEPTH) || (32'(node_q) >= N_NODES);
    end

    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        thr_d       = thr_q;
        node_d      = node_q;
        depth_d     = depth_q;
        out_depth_d = out_depth_q;
        out_anom_d  = out_anom_q;
        cnt_d       = cnt_q;
        shd_vld_d   = shd_vld_q;
        shd_addr_d  = shd_addr_q;
        shd_node_d  = shd_node_q;
        cfg_err_d   = cfg_we && !((state_q == IDLE) && addr_ok);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sample_d   = in_data;
                    thr_d      = anom_thr;
                    node_d     = '0;
                    depth_d    = '0;
                    shd_vld_d  = tbl_we;
                    shd_addr_d = cfg_addr;
                    shd_node_d = old_node;
                    state_d    = WALK;
                end
            end
            WALK: begin
                if (at_leaf) begin
                    out_depth_d = depth_q;
                    out_anom_d  = (depth_q < thr_q);
                    state_d     = DONE;
                end else begin
                    node_d  = {node_q[NODE_W-2:0], 1'b0} + (go_left ? NODE_W'(1) : NODE_W'(2));
                    depth_d = depth_q + DEPTH_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (out_anom_q && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sample_q    <= '0;
            thr_q       <= '0;
            node_q      <= '0;
            depth_q     <= '0;
            out_depth_q <= '0;
            out_anom_q  <= 1'b0;
            cnt_q       <= '0;
            cfg_err_q   <= 1'b0;
            shd_vld_q   <= 1'b0;
            shd_addr_q  <= '0;
            shd_node_q  <= LEAF_NODE;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            thr_q       <= thr_d;
            node_q      <= node_d;
            depth_q     <= depth_d;
            out_depth_q <= out_depth_d;
            out_anom_q  <= out_anom_d;
            cnt_q       <= cnt_d;
            cfg_err_q   <= cfg_err_d;
            shd_vld_q   <= shd_vld_d;
            shd_addr_q  <= shd_addr_d;
            shd_node_q  <= shd_node_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign out_depth     = out_depth_q;
    assign out_anomaly   = out_anom_q;
    assign anomaly_count = cnt_q;
    assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_itree_path_scorer.sv
// Directed bench for itree_path_scorer: a transaction-level tree model checked
// every cycle, plus literal expectations from hand-walked tree paths.
module tb_itree_path_scorer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [0:0]  cfg_feat;
    logic [7:0]  cfg_thresh;
    logic        cfg_leaf;
    logic        cfg_err, cfg_err_s;
    logic [1:0]  anom_thr;
    logic        in_valid;
    logic        in_ready, in_ready_s;
    logic [15:0] in_data;
    logic        out_valid, out_valid_s;
    logic        out_ready;
    logic [1:0]  out_depth, out_depth_s;
    logic        out_anomaly, out_anomaly_s;
    logic [15:0] anomaly_count;
    logic [1:0]  anomaly_count_s;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    itree_path_scorer dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_feat(cfg_feat), .cfg_thresh(cfg_thresh), .cfg_leaf(cfg_leaf),
        .cfg_err(cfg_err), .anom_thr(anom_thr), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_depth(out_depth), .out_anomaly(out_anomaly),
        .anomaly_count(anomaly_count)
    );

    itree_path_scorer #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_feat(cfg_feat), .cfg_thresh(cfg_thresh), .cfg_leaf(cfg_leaf),
        .cfg_err(cfg_err_s), .anom_thr(anom_thr), .in_valid(in_valid),
        .in_ready(in_ready_s), .in_data(in_data), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_depth(out_depth_s), .out_anomaly(out_anomaly_s),
        .anomaly_count(anomaly_count_s)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: node table, walk by the split rules, latency by formula.
    bit m_leaf [7];
    int m_feat [7];
    int m_thr  [7];
    bit m_busy, m_anom, m_err;
    int m_wait, m_depth, m_cnt, m_cnt_sat;

    function automatic int walk(input logic [15:0] s);
        int n, d, f, v;
        n = 0;
        d = 0;
        while (d < 3 && n < 7 && !m_leaf[n]) begin
            f = (m_feat[n] < 2) ? m_feat[n] : 0;
            v = int'(s[f*8 +: 8]);
            n = (v < m_thr[n]) ? 2*n + 1 : 2*n + 2;
            d++;
        end
        return d;
    endfunction

    always @(negedge clk) begin
        bit idle;
        if (!reset) begin
            m_busy = 0; m_wait = 0; m_err = 0; m_cnt = 0; m_cnt_sat = 0;
            for (int i = 0; i < 7; i++) begin
                m_leaf[i] = 1; m_feat[i] = 0; m_thr[i] = 0;
            end
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_depth", out_depth, 0);
            chk("rst_out_anomaly", out_anomaly, 0);
            chk("rst_cfg_err", cfg_err, 0);
            chk("rst_count", anomaly_count, 0);
            chk("rst_count_sat", anomaly_count_s, 0);
        end else begin
            chk("in_ready", in_ready, !m_busy);
            chk("out_valid", out_valid, m_busy && m_wait == 0);
            chk("cfg_err", cfg_err, m_err);
            chk("count", anomaly_count, m_cnt);
            chk("count_sat", anomaly_count_s, m_cnt_sat);
            chk("sat_out_valid", out_valid_s, m_busy && m_wait == 0);
            if (m_busy && m_wait == 0) begin
                chk("out_depth", out_depth, m_depth);
                chk("out_anomaly", out_anomaly, m_anom);
            end
            // predict the next edge
            idle  = !m_busy;
            m_err = cfg_we && !(idle && cfg_addr < 7);
            if (m_busy) begin
                if (m_wait == 0) begin
                    if (out_ready) begin
                        m_busy = 0;
                        if (m_anom) begin
                            if (m_cnt < 65535) m_cnt++;
                            if (m_cnt_sat < 3) m_cnt_sat++;
                        end
                    end
                end else begin
                    m_wait--;
                end
            end else if (in_valid) begin
                m_depth = walk(in_data);
                m_anom  = m_depth < int'(anom_thr);
                m_busy  = 1;
                m_wait  = m_depth + 1;
            end
            if (cfg_we && idle && cfg_addr < 7) begin
                m_leaf[cfg_addr] = cfg_leaf;
                m_feat[cfg_addr] = int'(cfg_feat);
                m_thr[cfg_addr]  = int'(cfg_thresh);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic program_node(input int a, input bit lf, input int f, input int th);
        cfg_we     = 1'b1;
        cfg_addr   = a[2:0];
        cfg_leaf   = lf;
        cfg_feat   = f[0:0];
        cfg_thresh = th[7:0];
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_sample(input logic [15:0] d, input int thr);
        chk("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        anom_thr = thr[1:0];
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string nm, input int ed, input int ea, input int elat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            chk({nm, "_latency"}, lat, elat);
            chk({nm, "_depth"}, out_depth, ed);
            chk({nm, "_anomaly"}, out_anomaly, ea);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_feat = '0; cfg_thresh = '0;
        cfg_leaf = 1'b0; anom_thr = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();

        // Unprogrammed table: root is a leaf
        start_sample(16'h0520, 1);
        wait_result("t1", 0, 1, 1);
        handshake();
        chk("t1_count", anomaly_count, 1);

        // Left walk 0 -> 1 -> 3
        program_node(0, 0, 0, 8'h55);
        program_node(1, 0, 1, 8'h10);
        start_sample(16'h0520, 2);
        wait_result("t2", 2, 0, 3);
        handshake();

        // Right walk to maximum depth, equality goes right
        program_node(2, 0, 0, 8'h55);
        program_node(6, 0, 0, 8'h55);
        start_sample(16'h0055, 3);
        wait_result("t3", 3, 0, 4);
        handshake();

        // Backpressure with a second sample waiting
        start_sample(16'h0520, 2);
        wait_result("t4a", 2, 0, 3);
        in_valid = 1'b1; in_data = 16'h0055; anom_thr = 2'd3;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_depth", out_depth, 2);
            chk("t4_hold_ready", in_ready, 0);
            tick();
        end
        handshake();
        chk("t4_ready_after", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t4_accepted", in_ready, 0);
        wait_result("t4b", 3, 0, 4);
        handshake();

        // Write during WALK is rejected
        start_sample(16'h0520, 2);
        program_node(1, 1, 0, 0);
        chk("t5_err_walk", cfg_err, 1);
        wait_result("t5a", 2, 0, 2);
        handshake();
        start_sample(16'h0520, 2);
        wait_result("t5b", 2, 0, 3);
        handshake();
        program_node(7, 0, 0, 8'h11);
        chk("t5_err_addr", cfg_err, 1);
        tick();
        chk("t5_err_clear", cfg_err, 0);

        // Write in the accepting cycle: this sample sees the old table
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_leaf = 1'b1; cfg_feat = '0; cfg_thresh = '0;
        in_valid = 1'b1; in_data = 16'h0520; anom_thr = 2'd2;
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        chk("t5_err_same", cfg_err, 0);
        wait_result("t5c", 2, 0, 3);
        handshake();
        start_sample(16'h0520, 2);
        wait_result("t5d", 1, 1, 2);
        handshake();

        // Reset mid-walk, then saturation
        start_sample(16'h0055, 3);
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_count", anomaly_count, 0);
        tick();
        reset = 1'b1;
        tick();
        start_sample(16'h0055, 3);
        wait_result("t6_leaf", 0, 1, 1);
        handshake();
        for (int i = 0; i < 4; i++) begin
            start_sample(16'h0520, 1);
            wait_result("t6_sat", 0, 1, 1);
            handshake();
        end
        chk("t6_count", anomaly_count, 5);
        chk("t6_count_sat", anomaly_count_s, 3);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
